uart_cmd_ctl: RTL

Parametrised successor to the single-purpose UART LED/motor controller. Consumes received bytes from the UART receiver, parses fixed 5-byte command frames with checksum and inter-byte timeout, and drives NUM_LED LED outputs and NUM_CH glitch-free PWM channels. Sits between the rx byte stream and the board LED/motor-driver pins, in the main system clock domain.

---
 rtl/uart_cmd_ctl_if.sv | 26 ++
 rtl/uart_cmd_ctl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctl_if.sv
// uart_cmd_ctl_if: byte-stream and frame-status bundle between a UART
// receiver / host logic and the command controller.
//   rx_data   : received byte
//   rx_valid  : one-cycle strobe, rx_data valid
//   frame_ok  : one-cycle pulse, frame accepted and executed
//   frame_err : one-cycle pulse, frame rejected
//   err_code  : last error cause (0 none, 1 checksum, 2 bad cmd/chan, 3 timeout)
//   busy      : parser is inside a frame
interface uart_cmd_ctl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output rx_data, rx_valid,
        input  frame_ok, frame_err, err_code, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output frame_ok, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_cmd_ctl.sv
// uart_cmd_ctl: parses 5-byte command frames (AA cmd chan val chk) from the
// rx byte stream and drives LED outputs and edge-aligned PWM channels.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : rx byte stream in, frame status out (uart_cmd_ctl_if.slave)
//   led   : LED drive, 1 = on
//   pwm   : PWM outputs, duty/256 high time, shared phase
module uart_cmd_ctl #(
    parameter int NUM_LED     = 2,
    parameter int NUM_CH      = 4,
    parameter int PWM_DIV     = 192,
    parameter int TIMEOUT_CYC = 49152
) (
    input  logic                clk,
    input  logic                reset,
    uart_cmd_ctl_if.slave       bus,
    output logic [NUM_LED-1:0]  led,
    output logic [NUM_CH-1:0]   pwm
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [7:0] HDR      = 8'hAA;
    localparam logic [7:0] CMD_LED  = 8'h01;
    localparam logic [7:0] CMD_DUTY = 8'h02;
    localparam logic [7:0] CMD_STOP = 8'h03;

    typedef enum logic [2:0] {IDLE, CMD, CHAN, VAL, CHK, EXEC} state_t;

    state_t                  state;
    logic [7:0]              cmd_q, chan_q, val_q;
    logic [TW-1:0]           tmo;
    logic [NUM_CH-1:0][7:0]  duty, shadow;
    logic [PW-1:0]           presc;
    logic [7:0]              phase;
    logic                    frame_ok, frame_err;
    logic [1:0]              err_code;

    logic chk_bad, chan_ok, cmd_bad, exec_go, stop_now, tick;

    // Frame verdict is formed while the checksum byte is on the bus, so
    // outputs and the status pulse all change on the edge that enters EXEC.
    always_comb begin
        chk_bad  = (bus.rx_data != (cmd_q ^ chan_q ^ val_q));
        chan_ok  = (32'(chan_q) < 32'(NUM_CH));
        cmd_bad  = !((cmd_q == CMD_LED) || (cmd_q == CMD_STOP) ||
                     ((cmd_q == CMD_DUTY) && chan_ok));
        exec_go  = (state == CHK) && bus.rx_valid;
        stop_now = exec_go && !chk_bad && (cmd_q == CMD_STOP);
        tick     = (presc == PW'(PWM_DIV - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            chan_q    <= '0;
            val_q     <= '0;
            tmo       <= '0;
            led       <= '0;
            duty      <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                // EXEC behaves like IDLE for an incoming byte so frames may
                // be sent back to back.
                IDLE, EXEC: begin
                    tmo   <= '0;
                    state <= (bus.rx_valid && bus.rx_data == HDR) ? CMD : IDLE;
                end
                CMD, CHAN, VAL, CHK: begin
                    if (bus.rx_valid) begin
                        tmo <= '0;
                        case (state)
                            CMD:     begin cmd_q  <= bus.rx_data; state <= CHAN; end
                            CHAN:    begin chan_q <= bus.rx_data; state <= VAL;  end
                            VAL:     begin val_q  <= bus.rx_data; state <= CHK;  end
                            default: begin
                                state <= EXEC;
                                if (chk_bad) begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'd1;
                                end else if (cmd_bad) begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'd2;
                                end else begin
                                    frame_ok <= 1'b1;
                                    err_code <= 2'd0;
                                    case (cmd_q)
                                        CMD_LED:  led <= val_q[NUM_LED-1:0];
                                        CMD_DUTY: duty[chan_q[CW-1:0]] <= val_q;
                                        default: begin
                                            led  <= '0;
                                            duty <= '0;
                                        end
                                    endcase
                                end
                            end
                        endcase
                    end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                        // counter would reach TIMEOUT_CYC this edge
                        state     <= IDLE;
                        tmo       <= '0;
                        frame_err <= 1'b1;
                        err_code  <= 2'd3;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // PWM: shadow duty only reloads at phase wrap so a duty write never
    // produces a runt pulse; all-stop bypasses the shadow and the output reg.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            phase  <= '0;
            shadow <= '0;
            pwm    <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) phase <= phase + 8'd1;
            if (stop_now) begin
                shadow <= '0;
                pwm    <= '0;
            end else begin
                if (tick && phase == 8'hFF) shadow <= duty;
                for (int i = 0; i < NUM_CH; i++)
                    pwm[i] <= (phase < shadow[i]);
            end
        end
    end

    assign bus.frame_ok  = frame_ok;
    assign bus.frame_err = frame_err;
    assign bus.err_code  = err_code;
    assign bus.busy      = (state != IDLE);
endmodule
